multicycle_control: RTL and testbench

- Multi-cycle control sequencer directly downstream of the 3-to-8 opcode decoder.
- Consumes the one-hot decode lines Di[7:0] and sequences fetch/decode/execute/memory/writeback.
- Drives the datapath strobes: IR load, PC increment, ALU, memory, register write.
- Checks Di for legal one-hot form and handles halt, branch and memory-timeout conditions.

---
 rtl/multicycle_control_pkg.sv | 43 ++++
 rtl/multicycle_control_if.sv | 36 +++
 rtl/multicycle_control_onehot_check.sv | 21 ++
 rtl/multicycle_control.sv | 140 ++++++++++++++
 tb/tb_multicycle_control.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle control sequencer: FSM states,
// one-hot opcode bit positions and ALU operation codes.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALTED  = 3'd6,
        ST_ERROR   = 3'd7
    } state_e;

    // Bit index of each opcode within the decoder's one-hot lines.
    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_LOAD  = 3'd4,
        OP_STORE = 3'd5,
        OP_BEQ   = 3'd6,
        OP_HALT  = 3'd7
    } opcode_e;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    // LOAD/STORE add for the address; BEQ subtracts to compare.
    function automatic logic [2:0] alu_code(opcode_e op);
        case (op)
            OP_SUB, OP_BEQ: return ALU_SUB;
            OP_AND:         return ALU_AND;
            OP_OR:          return ALU_OR;
            default:        return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Handshake, decode and datapath-strobe bundle between the sequencer
// (slave side) and its fetch/decode/datapath environment (master side).
interface multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             instr_valid;
    logic             instr_ready;
    logic [7:0]       di;
    logic             zero_flag;
    logic             mem_ack;
    logic             ir_load;
    logic             pc_inc;
    logic             alu_en;
    logic [2:0]       alu_op;
    logic             branch_take;
    logic             mem_rd;
    logic             mem_wr;
    logic             reg_we;
    logic             mem_to_reg;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output run, instr_valid, di, zero_flag, mem_ack,
        input  instr_ready, ir_load, pc_inc, alu_en, alu_op, branch_take,
               mem_rd, mem_wr, reg_we, mem_to_reg, halted, err, instr_count
    );

    modport slave (
        input  run, instr_valid, di, zero_flag, mem_ack,
        output instr_ready, ir_load, pc_inc, alu_en, alu_op, branch_take,
               mem_rd, mem_wr, reg_we, mem_to_reg, halted, err, instr_count
    );
endinterface

// File: rtl/multicycle_control_onehot_check.sv
// Validates the decoder lines as exactly one-hot and returns the index of
// the set bit as an opcode.
module multicycle_control_onehot_check
    import multicycle_control_pkg::*;
(
    input  logic [7:0] di_i,
    output logic       legal_o,
    output opcode_e    op_o
);

    // x & (x-1) clears the lowest set bit, so zero means at most one bit set.
    assign legal_o = (di_i != 8'd0) && ((di_i & (di_i - 8'd1)) == 8'd0);

    always_comb begin
        op_o = OP_ADD;
        for (int i = 0; i < 8; i++) begin
            if (di_i[i]) op_o = opcode_e'(3'(i));
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer: walks fetch/decode/execute/memory/writeback
// for each one-hot opcode and drives the datapath strobes.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    multicycle_control_if.slave bus
);

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    opcode_e          op_q, op_d;
    logic [7:0]       tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic             di_legal;
    opcode_e          di_op;

    multicycle_control_onehot_check u_onehot_check (
        .di_i    (bus.di),
        .legal_o (di_legal),
        .op_o    (di_op)
    );

    always_comb begin
        // NOTE: every next-state value and output is defaulted first so no path infers a latch.
        state_d         = state_q;
        op_d            = op_q;
        tmo_d           = '0;
        retire          = 1'b0;
        bus.instr_ready = 1'b0;
        bus.ir_load     = 1'b0;
        bus.pc_inc      = 1'b0;
        bus.alu_en      = 1'b0;
        bus.alu_op      = ALU_ADD;
        bus.branch_take = 1'b0;
        bus.mem_rd      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.reg_we      = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.halted      = 1'b0;
        bus.err         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                bus.instr_ready = 1'b1;
                // A word accepted by the handshake is never dropped, even if run falls.
                if (bus.instr_valid) begin
                    bus.ir_load = 1'b1;
                    bus.pc_inc  = 1'b1;
                    state_d     = ST_DECODE;
                end else if (!bus.run) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE: begin
                op_d = di_op;
                if (!di_legal) begin
                    state_d = ST_ERROR;
                end else if (di_op == OP_HALT) begin
                    retire  = 1'b1;
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                bus.alu_en = 1'b1;
                bus.alu_op = alu_code(op_q);
                case (op_q)
                    OP_LOAD, OP_STORE: state_d = ST_MEM;
                    OP_BEQ: begin
                        bus.branch_take = bus.zero_flag;
                        retire          = 1'b1;
                        state_d         = ST_FETCH;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                bus.mem_rd = (op_q == OP_LOAD);
                bus.mem_wr = (op_q == OP_STORE);
                // An ack on the last allowed cycle still completes the access.
                if (bus.mem_ack) begin
                    if (op_q == OP_LOAD) begin
                        state_d = ST_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_WB: begin
                bus.reg_we     = 1'b1;
                bus.mem_to_reg = (op_q == OP_LOAD);
                retire         = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_HALTED: begin
                bus.halted = 1'b1;
                if (!bus.run) state_d = ST_IDLE;
            end
            default: begin
                bus.err = 1'b1;
            end
        endcase

        cnt_d = (retire && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    end

    assign bus.instr_count = cnt_q;

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            tmo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, corner
// sequences and a randomized instruction stream against a trace model.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 4;

    localparam logic [10:0] M_R   = 11'h001;
    localparam logic [10:0] M_IL  = 11'h002;
    localparam logic [10:0] M_PI  = 11'h004;
    localparam logic [10:0] M_AE  = 11'h008;
    localparam logic [10:0] M_BT  = 11'h010;
    localparam logic [10:0] M_MR  = 11'h020;
    localparam logic [10:0] M_MW  = 11'h040;
    localparam logic [10:0] M_WE  = 11'h080;
    localparam logic [10:0] M_MTR = 11'h100;
    localparam logic [10:0] M_H   = 11'h200;
    localparam logic [10:0] M_E   = 11'h400;
    localparam logic [10:0] M_FT  = M_R | M_IL | M_PI;

    typedef struct packed {
        logic             run;
        logic             valid;
        logic [7:0]       di;
        logic             zf;
        logic             ack;
        logic [10:0]      mask;
        logic [2:0]       aluop;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [10:0] act_mask();
        return {bus.err, bus.halted, bus.mem_to_reg, bus.reg_we, bus.mem_wr, bus.mem_rd,
                bus.branch_take, bus.alu_en, bus.pc_inc, bus.ir_load, bus.instr_ready};
    endfunction

    function automatic int sat(input int n);
        return (n > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : n;
    endfunction

    // Called at posedge+1: drive one cycle of inputs, sample before the next edge.
    task automatic cyc(input string name, input logic run, input logic valid, input logic [7:0] di,
                       input logic zf, input logic ack, input logic [10:0] mask,
                       input logic [2:0] aluop, input int cnt);
        bus.run         = run;
        bus.instr_valid = valid;
        bus.di          = di;
        bus.zero_flag   = zf;
        bus.mem_ack     = ack;
        #3;
        check(name, {18'd0, bus.alu_op, act_mask()}, {18'd0, aluop, mask});
        check({name, "_cnt"}, 32'(bus.instr_count), 32'(cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.run = 1'b0; bus.instr_valid = 1'b0; bus.di = 8'd0;
        bus.zero_flag = 1'b0; bus.mem_ack = 1'b0;
        rst_n = 1'b0;
        #3;
        check("reset_outs", {18'd0, bus.alu_op, act_mask()}, 32'd0);
        check("reset_cnt", 32'(bus.instr_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic tv(input logic run, input logic valid, input logic [7:0] di, input logic zf,
                      input logic ack, input logic [10:0] mask, input logic [2:0] aluop, input int cnt);
        vecs.push_back('{run, valid, di, zf, ack, mask, aluop, CNT_W'(cnt)});
    endtask

    logic [2:0] alu_tab [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd1};
    logic [7:0] bad_di  [2] = '{8'h00, 8'h03};
    int         retired;
    int         gap;
    int         lat;
    int         opi;
    logic       zf;
    logic [7:0] di;
    logic [10:0] m;

    initial begin
        rst_n = 1'b0;
        bus.run = 1'b0; bus.instr_valid = 1'b0; bus.di = 8'd0;
        bus.zero_flag = 1'b0; bus.mem_ack = 1'b0;

        // run, valid, di, zero_flag, mem_ack | expected strobes, alu_op, instr_count
        tv(1, 0, 8'h00, 0, 0, 11'd0,       0, 0);
        tv(1, 1, 8'h01, 0, 0, M_FT,        0, 0);
        tv(1, 1, 8'h01, 0, 1, 11'd0,       0, 0);
        tv(0, 0, 8'h01, 0, 0, M_AE,        0, 0);
        tv(1, 0, 8'h01, 0, 0, M_WE,        0, 0);
        tv(1, 1, 8'h10, 0, 0, M_FT,        0, 1);
        tv(1, 0, 8'h10, 0, 0, 11'd0,       0, 1);
        tv(1, 0, 8'h10, 0, 0, M_AE,        0, 1);
        tv(1, 0, 8'h10, 0, 0, M_MR,        0, 1);
        tv(1, 0, 8'h10, 0, 0, M_MR,        0, 1);
        tv(1, 0, 8'h10, 0, 1, M_MR,        0, 1);
        tv(1, 0, 8'h10, 0, 0, M_WE | M_MTR, 0, 1);
        tv(1, 1, 8'h40, 0, 0, M_FT,        0, 2);
        tv(1, 0, 8'h40, 0, 0, 11'd0,       0, 2);
        tv(1, 0, 8'h40, 1, 0, M_AE | M_BT, 1, 2);
        tv(1, 1, 8'h40, 1, 0, M_FT,        0, 3);
        tv(1, 0, 8'h40, 1, 0, 11'd0,       0, 3);
        tv(1, 0, 8'h40, 0, 0, M_AE,        1, 3);
        tv(1, 1, 8'h02, 0, 0, M_FT,        0, 4);
        tv(1, 0, 8'h02, 0, 0, 11'd0,       0, 4);
        tv(1, 0, 8'h02, 0, 0, M_AE,        1, 4);
        tv(1, 0, 8'h02, 0, 0, M_WE,        0, 4);
        tv(1, 1, 8'h20, 0, 0, M_FT,        0, 5);
        tv(1, 0, 8'h20, 0, 0, 11'd0,       0, 5);
        tv(1, 0, 8'h20, 0, 0, M_AE,        0, 5);
        tv(1, 0, 8'h20, 0, 1, M_MW,        0, 5);
        tv(1, 1, 8'h04, 0, 0, M_FT,        0, 6);
        tv(1, 0, 8'h04, 0, 0, 11'd0,       0, 6);
        tv(1, 0, 8'h04, 0, 0, M_AE,        2, 6);
        tv(1, 0, 8'h04, 0, 0, M_WE,        0, 6);
        tv(1, 1, 8'h08, 0, 0, M_FT,        0, 7);
        tv(1, 0, 8'h08, 0, 0, 11'd0,       0, 7);
        tv(1, 0, 8'h08, 0, 0, M_AE,        3, 7);
        tv(1, 0, 8'h08, 0, 0, M_WE,        0, 7);
        tv(1, 0, 8'h00, 0, 0, M_R,         0, 8);
        tv(0, 0, 8'h00, 0, 0, M_R,         0, 8);
        tv(0, 1, 8'h00, 0, 1, 11'd0,       0, 8);
        tv(1, 0, 8'h00, 0, 0, 11'd0,       0, 8);
        tv(1, 1, 8'h80, 0, 0, M_FT,        0, 8);
        tv(1, 0, 8'h80, 0, 0, 11'd0,       0, 8);
        tv(1, 0, 8'h80, 0, 0, M_H,         0, 9);
        tv(0, 0, 8'h80, 0, 0, M_H,         0, 9);
        tv(0, 0, 8'h00, 0, 0, 11'd0,       0, 9);

        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            cyc($sformatf("vec%0d", i), vecs[i].run, vecs[i].valid, vecs[i].di, vecs[i].zf,
                vecs[i].ack, vecs[i].mask, vecs[i].aluop, int'(vecs[i].cnt));
        end

        // Illegal decode lines: error next cycle, sticky until reset.
        for (int b = 0; b < 2; b++) begin
            do_reset();
            cyc("ill_idle",   1, 0, bad_di[b], 0, 0, 11'd0, 0, 0);
            cyc("ill_fetch",  1, 1, bad_di[b], 0, 0, M_FT,  0, 0);
            cyc("ill_decode", 1, 0, bad_di[b], 0, 0, 11'd0, 0, 0);
            cyc("ill_err0",   1, 1, 8'h01,     1, 1, M_E,   0, 0);
            cyc("ill_err1",   0, 1, 8'h01,     0, 1, M_E,   0, 0);
            do_reset();
            cyc("ill_cleared", 0, 0, 8'h00, 0, 0, 11'd0, 0, 0);
        end

        // STORE never acknowledged: 15 mem_wr cycles, then error.
        do_reset();
        cyc("to_idle",  1, 0, 8'h20, 0, 0, 11'd0, 0, 0);
        cyc("to_fetch", 1, 1, 8'h20, 0, 0, M_FT,  0, 0);
        cyc("to_dec",   1, 0, 8'h20, 0, 0, 11'd0, 0, 0);
        cyc("to_exec",  1, 0, 8'h20, 0, 0, M_AE,  0, 0);
        for (int k = 1; k <= MEM_TIMEOUT; k++)
            cyc($sformatf("to_mem%0d", k), 1, 0, 8'h20, 0, 0, M_MW, 0, 0);
        cyc("to_err0", 1, 0, 8'h20, 0, 1, M_E, 0, 0);
        cyc("to_err1", 1, 0, 8'h20, 0, 0, M_E, 0, 0);

        // Ack on the final allowed cycle wins over the timeout.
        do_reset();
        cyc("ak_idle",  1, 0, 8'h20, 0, 0, 11'd0, 0, 0);
        cyc("ak_fetch", 1, 1, 8'h20, 0, 0, M_FT,  0, 0);
        cyc("ak_dec",   1, 0, 8'h20, 0, 0, 11'd0, 0, 0);
        cyc("ak_exec",  1, 0, 8'h20, 0, 0, M_AE,  0, 0);
        for (int k = 1; k <= MEM_TIMEOUT; k++)
            cyc($sformatf("ak_mem%0d", k), 1, 0, 8'h20, 0, (k == MEM_TIMEOUT), M_MW, 0, 0);
        cyc("ak_fetch2", 1, 0, 8'h00, 0, 0, M_R, 0, 1);

        // Asynchronous reset in the middle of a LOAD memory wait.
        cyc("ar_fetch", 1, 1, 8'h10, 0, 0, M_FT,  0, 1);
        cyc("ar_dec",   1, 0, 8'h10, 0, 0, 11'd0, 0, 1);
        cyc("ar_exec",  1, 0, 8'h10, 0, 0, M_AE,  0, 1);
        bus.mem_ack = 1'b0;
        #3;
        check("ar_mem_rd", 32'(bus.mem_rd), 32'd1);
        rst_n = 1'b0;
        #1;
        check("ar_outs", {18'd0, bus.alu_op, act_mask()}, 32'd0);
        check("ar_cnt", 32'(bus.instr_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("ar_idle0", 0, 1, 8'h10, 0, 1, 11'd0, 0, 0);
        cyc("ar_idle1", 1, 0, 8'h10, 0, 0, 11'd0, 0, 0);
        cyc("ar_fetch2", 1, 0, 8'h10, 0, 0, M_R, 0, 0);

        // Random instruction stream, expanded by the instruction-level trace rules.
        do_reset();
        retired = 0;
        cyc("rnd_idle", 1, 0, 8'($urandom), 1'($urandom), 1'($urandom), 11'd0, 0, 0);
        for (int n = 0; n < 60; n++) begin
            opi = $urandom_range(0, 6);
            gap = $urandom_range(0, 2);
            lat = $urandom_range(1, MEM_TIMEOUT);
            zf  = 1'($urandom);
            di  = 8'd1 << opi;
            for (int g = 0; g < gap; g++)
                cyc($sformatf("rnd%0d_gap", n), 1, 0, 8'($urandom), 1'($urandom), 1'($urandom),
                    M_R, 0, sat(retired));
            cyc($sformatf("rnd%0d_fetch", n), 1, 1, di, 1'($urandom), 1'($urandom), M_FT, 0, sat(retired));
            cyc($sformatf("rnd%0d_dec", n), 1'($urandom), 1'($urandom), di, 1'($urandom), 1'($urandom),
                11'd0, 0, sat(retired));
            m = M_AE | ((opi == 6 && zf) ? M_BT : 11'd0);
            cyc($sformatf("rnd%0d_exec", n), 1'($urandom), 1'($urandom), 8'($urandom), zf, 1'($urandom),
                m, alu_tab[opi], sat(retired));
            if (opi == 4 || opi == 5) begin
                for (int k = 1; k <= lat; k++)
                    cyc($sformatf("rnd%0d_mem%0d", n, k), 1'($urandom), 1'($urandom), 8'($urandom),
                        1'($urandom), (k == lat), (opi == 4) ? M_MR : M_MW, 0, sat(retired));
            end
            if (opi <= 4)
                cyc($sformatf("rnd%0d_wb", n), 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
                    1'($urandom), M_WE | ((opi == 4) ? M_MTR : 11'd0), 0, sat(retired));
            retired++;
        end
        cyc("rnd_end", 1, 0, 8'h00, 0, 0, M_R, 0, sat(retired));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
